// File: rtl/sp_mac_pkg.sv
// Shared widths, operand beat layout, FSM encoding and the mix adder helper
// for the sp_double_mac feeder slice.
package sp_mac_pkg;

    localparam int A_W   = 4;
    localparam int B_W   = 8;
    localparam int MIX_W = 9;
    localparam int ACC_W = 26;

    typedef struct packed {
        logic [A_W-1:0] a1;
        logic [A_W-1:0] a2;
        logic [B_W-1:0] b1;
        logic [B_W-1:0] b2;
    } operand_beat_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DONE  = 2'd1,
        ST_CLEAR = 2'd2
    } feeder_state_e;

    // Sign-extend both activations by one bit so the sum can never overflow.
    function automatic logic [MIX_W-1:0] mix_sum(input logic [B_W-1:0] b1,
                                                 input logic [B_W-1:0] b2);
        return {b1[B_W-1], b1} + {b2[B_W-1], b2};
    endfunction

endpackage

// File: rtl/sp_mac_operand_fifo.sv
// Synchronous FIFO of operand beats; storage is not reset, the pointers and
// count are, so a reset flushes the contents.
module sp_mac_operand_fifo
    import sp_mac_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  operand_beat_t wdata,
    input  logic          pop,
    output operand_beat_t rdata,
    output logic          full,
    output logic          empty,
    output logic [PTR_W:0] count
);

    operand_beat_t     mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push_s, do_pop_s;

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Beat storage.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/sp_double_mac_feeder.sv
// Operand feeder for the sp_double_mac_unit chain: FIFO, issue, mix adder and
// K-beat framing FSM. Optional perf counters are enabled by FEEDER_PERF_EN.
module sp_double_mac_feeder
    import sp_mac_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int K_LEN_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [A_W-1:0]     s_a1,
    input  logic [A_W-1:0]     s_a2,
    input  logic [B_W-1:0]     s_b1,
    input  logic [B_W-1:0]     s_b2,
    input  logic [K_LEN_W-1:0] cfg_k_len,
    input  logic               stall,
    output logic               pulse,
    output logic [A_W-1:0]     out_a1,
    output logic [A_W-1:0]     out_a2,
    output logic [B_W-1:0]     out_b1,
    output logic [B_W-1:0]     out_b2,
    output logic [MIX_W-1:0]   out_mix,
    output logic               done,
    output logic               mac_clr
`ifdef FEEDER_PERF_EN
   ,output logic [31:0]        perf_beats,
    output logic [31:0]        perf_starve
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    operand_beat_t      in_beat_s, head_beat_s;
    logic               fifo_full_s, fifo_empty_s, push_s, issue_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [K_LEN_W-1:0] k_cfg_s, k_cur_s;

    feeder_state_e      state_q, state_d;
    logic [K_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [K_LEN_W-1:0] k_len_q, k_len_d;
    logic               pulse_q, pulse_d;
    operand_beat_t      out_beat_q, out_beat_d;
    logic [MIX_W-1:0]   mix_q, mix_d;
    logic               done_q, done_d;
    logic               mac_clr_q, mac_clr_d;

    assign in_beat_s = '{a1: s_a1, a2: s_a2, b1: s_b1, b2: s_b2};
    assign push_s    = s_valid && !fifo_full_s;

    sp_mac_operand_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (in_beat_s),
        .pop   (issue_s),
        .rdata (head_beat_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Issue, framing and FSM next-state; k_len is only taken from cfg at beat 0.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        k_len_d    = k_len_q;
        pulse_d    = 1'b0;
        out_beat_d = out_beat_q;
        mix_d      = mix_q;
        done_d     = 1'b0;
        mac_clr_d  = 1'b0;
        issue_s    = 1'b0;
        k_cfg_s    = (cfg_k_len == '0) ? K_LEN_W'(1) : cfg_k_len;
        k_cur_s    = (beat_cnt_q == '0) ? k_cfg_s : k_len_q;
        case (state_q)
            ST_RUN: begin
                if (!fifo_empty_s && !stall) begin
                    issue_s    = 1'b1;
                    pulse_d    = 1'b1;
                    out_beat_d = head_beat_s;
                    mix_d      = mix_sum(head_beat_s.b1, head_beat_s.b2);
                    k_len_d    = k_cur_s;
                    if (beat_cnt_q == k_cur_s - K_LEN_W'(1)) begin
                        beat_cnt_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + K_LEN_W'(1);
                    end
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                mac_clr_d = 1'b1;
                state_d   = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Datapath, strobe and FSM registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            beat_cnt_q <= '0;
            k_len_q    <= '0;
            pulse_q    <= 1'b0;
            out_beat_q <= '0;
            mix_q      <= '0;
            done_q     <= 1'b0;
            mac_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            k_len_q    <= k_len_d;
            pulse_q    <= pulse_d;
            out_beat_q <= out_beat_d;
            mix_q      <= mix_d;
            done_q     <= done_d;
            mac_clr_q  <= mac_clr_d;
        end
    end

    assign s_ready = (fifo_count_s != CNT_W'(FIFO_DEPTH));
    assign pulse   = pulse_q;
    assign out_a1  = out_beat_q.a1;
    assign out_a2  = out_beat_q.a2;
    assign out_b1  = out_beat_q.b1;
    assign out_b2  = out_beat_q.b2;
    assign out_mix = mix_q;
    assign done    = done_q;
    assign mac_clr = mac_clr_q;

`ifdef FEEDER_PERF_EN
    logic [31:0] perf_beats_q, perf_beats_d;
    logic [31:0] perf_starve_q, perf_starve_d;

    // Saturating event counters.
    always_comb begin
        perf_beats_d  = perf_beats_q;
        perf_starve_d = perf_starve_q;
        if (issue_s && (perf_beats_q != 32'hFFFF_FFFF)) begin
            perf_beats_d = perf_beats_q + 32'd1;
        end else begin
            perf_beats_d = perf_beats_q;
        end
        if ((state_q == ST_RUN) && fifo_empty_s && !stall &&
            (perf_starve_q != 32'hFFFF_FFFF)) begin
            perf_starve_d = perf_starve_q + 32'd1;
        end else begin
            perf_starve_d = perf_starve_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_beats_q  <= 32'd0;
            perf_starve_q <= 32'd0;
        end else begin
            perf_beats_q  <= perf_beats_d;
            perf_starve_q <= perf_starve_d;
        end
    end

    assign perf_beats  = perf_beats_q;
    assign perf_starve = perf_starve_q;
`endif

endmodule

// File: tb/tb_sp_double_mac_feeder.sv
// Directed self-checking bench for sp_double_mac_feeder (default build).
module tb_sp_double_mac_feeder;

    logic        clk = 1'b0;
    logic        reset, s_valid, s_ready, stall, pulse, done, mac_clr;
    logic [3:0]  s_a1, s_a2, out_a1, out_a2;
    logic [7:0]  s_b1, s_b2, out_b1, out_b2;
    logic [15:0] cfg_k_len;
    logic [8:0]  out_mix;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sp_double_mac_feeder dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_a1(s_a1), .s_a2(s_a2), .s_b1(s_b1), .s_b2(s_b2),
        .cfg_k_len(cfg_k_len), .stall(stall), .pulse(pulse),
        .out_a1(out_a1), .out_a2(out_a2), .out_b1(out_b1), .out_b2(out_b2),
        .out_mix(out_mix), .done(done), .mac_clr(mac_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int a1, input int a2, input int b1, input int b2);
        s_a1 = a1[3:0];
        s_a2 = a2[3:0];
        s_b1 = b1[7:0];
        s_b2 = b2[7:0];
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        stall   = 1'b0;
        set_beat(0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; stall = 1'b0; cfg_k_len = 16'd1;
        set_beat(0, 0, 0, 0);
        tick(); tick(); tick();
        checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL rst_pulse: got %0b expected 0", pulse); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b expected 0", done); end
        checks++; if (mac_clr !== 1'b0) begin failures++; $display("FAIL rst_mac_clr: got %0b expected 0", mac_clr); end
        checks++; if ({out_a1, out_a2, out_b1, out_b2} !== 24'h0) begin failures++; $display("FAIL rst_operands: got %h expected 0", {out_a1, out_a2, out_b1, out_b2}); end
        checks++; if (out_mix !== 9'h000) begin failures++; $display("FAIL rst_mix: got %h expected 000", out_mix); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready: got %0b expected 1", s_ready); end
        reset = 1'b0;
        tick(); tick();
        checks++; if (pulse !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_after_rst: got pulse=%0b done=%0b expected 0 0", pulse, done); end
    endtask

    task automatic test_k1();
        do_reset();
        cfg_k_len = 16'd1;
        set_beat(3, -2, 10, 20);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        checks++; if (pulse !== 1'b1) begin failures++; $display("FAIL k1_pulse: got %0b expected 1", pulse); end
        checks++; if ({out_a1, out_a2, out_b1, out_b2} !== {4'h3, 4'hE, 8'd10, 8'd20}) begin failures++; $display("FAIL k1_operands: got %h expected 3e0a14", {out_a1, out_a2, out_b1, out_b2}); end
        checks++; if (out_mix !== 9'd30) begin failures++; $display("FAIL k1_mix: got %0d expected 30", out_mix); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL k1_done_early: got %0b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1 || pulse !== 1'b0 || mac_clr !== 1'b0) begin failures++; $display("FAIL k1_done: got done=%0b pulse=%0b clr=%0b expected 1 0 0", done, pulse, mac_clr); end
        tick();
        checks++; if (mac_clr !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL k1_clr: got clr=%0b done=%0b expected 1 0", mac_clr, done); end
        tick();
        checks++; if (mac_clr !== 1'b0) begin failures++; $display("FAIL k1_clr_width: got %0b expected 0", mac_clr); end
    endtask

    task automatic test_mix();
        int         b1_tab [3] = '{-128, 127, 127};
        int         b2_tab [3] = '{-128, 127, -128};
        logic [8:0] exp_tab [3] = '{9'h100, 9'd254, 9'h1FF};
        do_reset();
        cfg_k_len = 16'd1;
        for (int i = 0; i < 3; i++) begin
            set_beat(1, 1, b1_tab[i], b2_tab[i]);
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            tick();
            checks++; if (pulse !== 1'b1 || out_mix !== exp_tab[i]) begin failures++; $display("FAIL mix_%0d: got pulse=%0b mix=%h expected 1 %h", i, pulse, out_mix, exp_tab[i]); end
            tick(); tick(); tick();
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        cfg_k_len = 16'd4;
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_beat(i, -i, 10 * i, i);
            s_valid = 1'b1;
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_%0d: got %0b expected 1", i, s_ready); end
            tick();
        end
        set_beat(5, -5, 50, 5);
        for (int i = 0; i < 2; i++) begin
            checks++; if (s_ready !== 1'b0 || pulse !== 1'b0) begin failures++; $display("FAIL bp_full_%0d: got ready=%0b pulse=%0b expected 0 0", i, s_ready, pulse); end
            tick();
        end
        stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 2) s_valid = 1'b0;
            checks++; if (pulse !== 1'b1 || out_b1 !== 8'(10 * i) || out_mix !== 9'(11 * i)) begin failures++; $display("FAIL bp_pulse_%0d: got pulse=%0b b1=%0d mix=%0d expected 1 %0d %0d", i, pulse, out_b1, out_mix, 10 * i, 11 * i); end
        end
        tick();
        checks++; if (done !== 1'b1 || pulse !== 1'b0) begin failures++; $display("FAIL bp_done: got done=%0b pulse=%0b expected 1 0", done, pulse); end
        tick();
        checks++; if (mac_clr !== 1'b1 || pulse !== 1'b0) begin failures++; $display("FAIL bp_clr: got clr=%0b pulse=%0b expected 1 0", mac_clr, pulse); end
        tick();
        checks++; if (pulse !== 1'b1 || out_b1 !== 8'd50) begin failures++; $display("FAIL bp_fifth: got pulse=%0b b1=%0d expected 1 50", pulse, out_b1); end
    endtask

    task automatic test_k3_stream();
        int pulse_t[$], done_t[$], clr_t[$], pb1[$];
        int exp_p [6] = '{0, 1, 2, 5, 6, 7};
        int idx = 0;
        logic rdy;
        do_reset();
        cfg_k_len = 16'd3;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (idx < 6) begin
                set_beat(1, 1, 10 * (idx + 1), 0);
                s_valid = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            rdy = s_ready;
            tick();
            if (s_valid && rdy) idx++;
            if (pulse === 1'b1) begin pulse_t.push_back(cyc); pb1.push_back(int'(out_b1)); end
            if (done === 1'b1) done_t.push_back(cyc);
            if (mac_clr === 1'b1) clr_t.push_back(cyc);
        end
        s_valid = 1'b0;
        checks++; if (pulse_t.size() != 6 || done_t.size() != 2 || clr_t.size() != 2) begin
            failures++; $display("FAIL k3_counts: got pulses=%0d dones=%0d clrs=%0d expected 6 2 2", pulse_t.size(), done_t.size(), clr_t.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (pulse_t[i] - pulse_t[0] != exp_p[i] || pb1[i] != 10 * (i + 1)) begin failures++; $display("FAIL k3_pulse_%0d: got offset=%0d b1=%0d expected %0d %0d", i, pulse_t[i] - pulse_t[0], pb1[i], exp_p[i], 10 * (i + 1)); end
            end
            checks++; if (done_t[0] - pulse_t[0] != 3 || done_t[1] - pulse_t[0] != 8) begin failures++; $display("FAIL k3_done: got offsets %0d %0d expected 3 8", done_t[0] - pulse_t[0], done_t[1] - pulse_t[0]); end
            checks++; if (clr_t[0] - pulse_t[0] != 4 || clr_t[1] - pulse_t[0] != 9) begin failures++; $display("FAIL k3_clr: got offsets %0d %0d expected 4 9", clr_t[0] - pulse_t[0], clr_t[1] - pulse_t[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int n_pulse = 0, n_done = 0, n_clr = 0, pulses_before_done = -1, idle_pulses = 0;
        do_reset();
        cfg_k_len = 16'd3;
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_beat(1, 1, i, 0);
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        checks++; if (pulse !== 1'b1 || out_b1 !== 8'd2) begin failures++; $display("FAIL mid_two_pulses: got pulse=%0b b1=%0d expected 1 2", pulse, out_b1); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pulse !== 1'b0 || done !== 1'b0 || s_ready !== 1'b1) begin failures++; $display("FAIL mid_after_rst: got pulse=%0b done=%0b ready=%0b expected 0 0 1", pulse, done, s_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pulse === 1'b1 || done === 1'b1) idle_pulses++;
        end
        checks++; if (idle_pulses != 0) begin failures++; $display("FAIL mid_flushed: got %0d stray strobes expected 0", idle_pulses); end
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 3) begin
                set_beat(2, 2, 7 * (cyc + 1), 1);
                s_valid = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            tick();
            if (pulse === 1'b1) n_pulse++;
            if (done === 1'b1) begin
                n_done++;
                if (pulses_before_done < 0) pulses_before_done = n_pulse;
            end
            if (mac_clr === 1'b1) n_clr++;
        end
        checks++; if (n_pulse != 3 || n_done != 1 || n_clr != 1) begin failures++; $display("FAIL mid_next_vec: got pulses=%0d dones=%0d clrs=%0d expected 3 1 1", n_pulse, n_done, n_clr); end
        checks++; if (pulses_before_done != 3) begin failures++; $display("FAIL mid_beat0: got %0d pulses before done expected 3", pulses_before_done); end
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; stall = 1'b0; cfg_k_len = 16'd1;
        set_beat(0, 0, 0, 0);
        test_reset();
        test_k1();
        test_mix();
        test_back_pressure();
        test_k3_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
